snes_pad_reader: RTL and testbench
==================================

# snes_pad_reader

Polls a SNES-style serial gamepad and produces the 8-bit `controller_report` consumed by the Dino Run game logic and renderer. It generates the latch and shift-clock waveforms and samples the serial data line. It then maps the raw button bits into the game's active-high report layout and issues a one-cycle `report_valid` strobe per completed poll. It sits between the board GPIO header and the game top level, in the same 50 MHz `clk` domain.

## Interface
Parameters:
- `POLL_DIV`, 833_333: cycles between successive latch rising edges (60 Hz at 50 MHz).
- `LATCH_CYC`, 600: cycles `pad_latch` is held high (12 µs).
- `HALF_CYC`, 300: cycles per half shift-clock period (6 µs).
- `NBITS`, 16: serial bits clocked per poll; legal values are 8..16.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: allows new polls to start.
- `pad_data` in 1: serial data from the pad; asynchronous; low = pressed.
- `pad_latch` out 1: latch strobe to the pad; active-high.
- `pad_clk` out 1: shift clock to the pad; idles high.
- `controller_report` out 8: mapped buttons, 1 = pressed.
  - [0] B (jump)
  - [1] Down
  - [2] Left
  - [3] Right
  - [4] Start (replay)
  - [5] Select
  - [6] A
  - [7] Up
- `report_valid` out 1: one-cycle pulse when a poll completes.

## Operation
- `pad_data` passes through a 2-flop synchronizer before any use.
- Raw serial order on the line, slots 0..15: B, Y, Select, Start, Up, Down, Left, Right, A, X, L, R, then 4 ID bits (ignored).
  - Slots at or beyond `NBITS` are treated as unpressed.
- FSM states: IDLE → LATCH → SHIFT_LO → SHIFT_HI → (SHIFT_LO for the next slot | DONE) → IDLE.
  - IDLE: `pad_latch`=0, `pad_clk`=1. The free-running poll counter counts 0..POLL_DIV-1. On wrap with `enable`=1, go to LATCH. On wrap with `enable`=0, stay in IDLE.
  - LATCH: `pad_latch`=1 for `LATCH_CYC` cycles, then go to SHIFT_LO for slot 0.
  - SHIFT_LO: `pad_clk`=0 for `HALF_CYC` cycles. The synchronized data is sampled, inverted, into raw bit k on the last cycle of this phase.
  - SHIFT_HI: `pad_clk`=1 for `HALF_CYC` cycles. If k = `NBITS`-1, go to DONE; otherwise increment k and return to SHIFT_LO.
  - DONE: one cycle. Load `controller_report` per the update rule, pulse `report_valid`, go to IDLE.
- The poll counter keeps running through the transaction, so the latch period is exactly `POLL_DIV` and is independent of transaction length. Legal configuration requires `POLL_DIV` > `LATCH_CYC` + 2·`NBITS`·`HALF_CYC` + 2.
- `HALF_CYC` ≥ 4, so the 2-cycle synchronizer lag stays inside the low phase.
- Dropping `enable` mid-transaction does not abort; the current poll completes normally.
- Reset values:
  - `pad_latch`=0, `pad_clk`=1, `controller_report`=0, `report_valid`=0.
  - FSM in IDLE, poll counter 0, raw/previous sample registers all 0 (unpressed).
- Reset asserted mid-transaction forces all reset values immediately. No partial report is ever published.

## Timing
- Define T as the first cycle with `pad_latch`=1.
- The first T after reset release falls POLL_DIV cycles after release, provided `enable`=1.
- `pad_latch` is high for T .. T+LATCH_CYC-1.
- Slot k starts at S_k = T+LATCH_CYC+2k·HALF_CYC.
  - `pad_clk` is low for S_k .. S_k+HALF_CYC-1.
  - Sampling happens at S_k+HALF_CYC-1.
  - `pad_clk` is high for S_k+HALF_CYC .. S_k+2·HALF_CYC-1.
- `report_valid`=1 and the new `controller_report` are both visible at D = T+LATCH_CYC+2·NBITS·HALF_CYC, for exactly one cycle of `report_valid`.
- `controller_report` is otherwise held constant between DONE cycles.
- No glitches: `pad_latch` and `pad_clk` come directly from flops.

## Configuration
- `PAD_DEBOUNCE_EN` defined: `controller_report` is loaded in DONE only if the new mapped 8-bit sample equals the previous poll's mapped sample; otherwise the report is held. The previous sample is updated every poll. `report_valid` still pulses every poll.
- `PAD_DEBOUNCE_EN` undefined: `controller_report` is loaded every DONE unconditionally.

## Structure
- Shared package `pad_pkg`:
  - FSM state enum.
  - Raw slot index constants (B=0 … R=11).
  - Report bit index constants (`RPT_JUMP`=0 … `RPT_UP`=7).
- Sub-module `pad_sync`: 2-flop synchronizer with async reset, reset value 1 (idle/unpressed line).

## Test plan
All scenarios use POLL_DIV=200, LATCH_CYC=4, HALF_CYC=4, NBITS=16, so D = T+132.
- Reset, then `enable`=1, pad model idle high:
  - first `pad_latch` rise at cycle 200 after release, high for 4 cycles;
  - 16 `pad_clk` low pulses of 4 cycles each;
  - `report_valid` at T+132 with report 8'h00.
- Pad model drives Start (slot 3) low → report 8'h10. Drives B+Right (slots 0, 7) → 8'h09.
- Checker confirms the latch period is exactly 200 cycles over 5 polls and the `report_valid` pulse width is 1.
- `enable` dropped at T+50:
  - current poll completes with `report_valid` at T+132;
  - no further `pad_latch` rise;
  - report holds.
- Reset asserted at T+70:
  - `pad_latch`=0, `pad_clk`=1, report 8'h00 immediately;
  - next latch rise 200 cycles after release.
- With `PAD_DEBOUNCE_EN`, Up (slot 4) pressed for one poll only → report stays 8'h00. Pressed for two consecutive polls → 8'h80 at the second DONE. Without the macro, 8'h80 appears at the first DONE.

Source files
------------

// File: rtl/pad_pkg.sv
// Shared definitions for the SNES pad reader: FSM states, serial slot and report bit indices.
// The mapping helper turns the sampled serial slots into the game's report layout.
package pad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_DONE
    } pad_state_t;

    // Position of each button in the pad's serial stream
    localparam int SLOT_B      = 0;
    localparam int SLOT_Y      = 1;
    localparam int SLOT_SELECT = 2;
    localparam int SLOT_START  = 3;
    localparam int SLOT_UP     = 4;
    localparam int SLOT_DOWN   = 5;
    localparam int SLOT_LEFT   = 6;
    localparam int SLOT_RIGHT  = 7;
    localparam int SLOT_A      = 8;
    localparam int SLOT_X      = 9;
    localparam int SLOT_L      = 10;
    localparam int SLOT_R      = 11;

    // Only slots 0..SLOT_A feed the report; later slots are never stored
    localparam int RAW_KEEP = SLOT_A + 1;

    localparam int RPT_JUMP   = 0;
    localparam int RPT_DOWN   = 1;
    localparam int RPT_LEFT   = 2;
    localparam int RPT_RIGHT  = 3;
    localparam int RPT_START  = 4;
    localparam int RPT_SELECT = 5;
    localparam int RPT_A      = 6;
    localparam int RPT_UP     = 7;

    function automatic logic [7:0] map_report(input logic [RAW_KEEP-1:0] raw);
        logic [7:0] rpt;
        rpt             = '0;
        rpt[RPT_JUMP]   = raw[SLOT_B];
        rpt[RPT_DOWN]   = raw[SLOT_DOWN];
        rpt[RPT_LEFT]   = raw[SLOT_LEFT];
        rpt[RPT_RIGHT]  = raw[SLOT_RIGHT];
        rpt[RPT_START]  = raw[SLOT_START];
        rpt[RPT_SELECT] = raw[SLOT_SELECT];
        rpt[RPT_A]      = raw[SLOT_A];
        rpt[RPT_UP]     = raw[SLOT_UP];
        return rpt;
    endfunction

endpackage

// File: rtl/pad_sync.sv
// Two-flop synchronizer for the pad's serial data line.
// Resets to 1 so the line reads as idle/unpressed until real data arrives.
module pad_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
        end else begin
            meta_reg <= async_in;
            sync_reg <= meta_reg;
        end
    end

    assign sync_out = sync_reg;

endmodule

// File: rtl/snes_pad_reader.sv
// SNES pad poller: drives latch/shift clock, samples the serial line, publishes an 8-bit report.
// Optional macro PAD_DEBOUNCE_EN: report only updates when two consecutive polls agree.
module snes_pad_reader
    import pad_pkg::*;
#(
    parameter int POLL_DIV  = 833_333,
    parameter int LATCH_CYC = 600,
    parameter int HALF_CYC  = 300,
    parameter int NBITS     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] controller_report,
    output logic       report_valid
);

    localparam int POLL_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int PH_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_DIV - 1);
    localparam logic [PH_W-1:0]   LATCH_LAST = PH_W'(LATCH_CYC - 1);
    localparam logic [PH_W-1:0]   HALF_LAST  = PH_W'(HALF_CYC - 1);
    localparam logic [3:0]        BIT_LAST   = 4'(NBITS - 1);

    pad_state_t        state_reg, state_next;
    logic [POLL_W-1:0] poll_cnt_reg;
    logic [PH_W-1:0]   phase_reg, phase_next;
    logic [3:0]        bit_reg, bit_next;
    logic              pad_latch_reg;
    logic              pad_clk_reg;
    logic [7:0]        report_reg;
    logic              report_valid_reg;

    logic              data_sync;
    logic              poll_wrap;
    logic              sample_now;
    logic              load_report;
    logic [RAW_KEEP-1:0] raw;
    logic [7:0]        mapped;

    pad_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (pad_data),
        .sync_out (data_sync)
    );

    assign poll_wrap   = (poll_cnt_reg == POLL_LAST);
    assign sample_now  = (state_reg == ST_SHIFT_LO) && (phase_reg == HALF_LAST);
    assign load_report = (state_reg == ST_SHIFT_HI) && (phase_reg == HALF_LAST)
                         && (bit_reg == BIT_LAST);

    // The poll counter never pauses, so the latch period is fixed regardless of FSM activity
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_cnt_reg <= '0;
        end else if (poll_wrap) begin
            poll_cnt_reg <= '0;
        end else begin
            poll_cnt_reg <= poll_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            phase_reg <= '0;
            bit_reg   <= '0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            bit_reg   <= bit_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg + 1'b1;
        bit_next   = bit_reg;
        case (state_reg)
            ST_IDLE: begin
                phase_next = '0;
                if (poll_wrap && enable) begin
                    state_next = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (phase_reg == LATCH_LAST) begin
                    state_next = ST_SHIFT_LO;
                    phase_next = '0;
                    bit_next   = '0;
                end
            end
            ST_SHIFT_LO: begin
                if (phase_reg == HALF_LAST) begin
                    state_next = ST_SHIFT_HI;
                    phase_next = '0;
                end
            end
            ST_SHIFT_HI: begin
                if (phase_reg == HALF_LAST) begin
                    phase_next = '0;
                    if (bit_reg == BIT_LAST) begin
                        state_next = ST_DONE;
                    end else begin
                        bit_next   = bit_reg + 1'b1;
                        state_next = ST_SHIFT_LO;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                phase_next = '0;
            end
            default: begin
                state_next = ST_IDLE;
                phase_next = '0;
            end
        endcase
    end

    // One sample flop per report-relevant slot; slots beyond NBITS stay unpressed
    for (genvar gi = 0; gi < RAW_KEEP; gi++) begin : g_raw
        if (gi < NBITS) begin : g_live
            logic slot_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    slot_reg <= 1'b0;
                end else if (sample_now && (bit_reg == 4'(gi))) begin
                    slot_reg <= ~data_sync;
                end
            end
            assign raw[gi] = slot_reg;
        end else begin : g_absent
            assign raw[gi] = 1'b0;
        end
    end

    assign mapped = map_report(raw);

    // Pad strobes are registered from the next state so they change with the state, glitch-free
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pad_latch_reg    <= 1'b0;
            pad_clk_reg      <= 1'b1;
            report_valid_reg <= 1'b0;
        end else begin
            pad_latch_reg    <= (state_next == ST_LATCH);
            pad_clk_reg      <= (state_next != ST_SHIFT_LO);
            report_valid_reg <= load_report;
        end
    end

`ifdef PAD_DEBOUNCE_EN
    logic [7:0] prev_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_reg   <= '0;
            report_reg <= '0;
        end else if (load_report) begin
            prev_reg <= mapped;
            if (mapped == prev_reg) begin
                report_reg <= mapped;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            report_reg <= '0;
        end else if (load_report) begin
            report_reg <= mapped;
        end
    end
`endif

    assign pad_latch         = pad_latch_reg;
    assign pad_clk           = pad_clk_reg;
    assign controller_report = report_reg;
    assign report_valid      = report_valid_reg;

endmodule

// File: tb/tb_snes_pad_reader.sv
// Bench for snes_pad_reader with a behavioural SNES pad and a report model built from button sets.
// Handles both the default build and PAD_DEBOUNCE_EN.
module tb_snes_pad_reader;

    localparam int POLL_DIV  = 200;
    localparam int LATCH_CYC = 4;
    localparam int HALF_CYC  = 4;
    localparam int NBITS     = 16;
    localparam int D_OFS     = LATCH_CYC + 2 * NBITS * HALF_CYC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       pad_data;
    logic       pad_latch;
    logic       pad_clk;
    logic [7:0] controller_report;
    logic       report_valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int polls = 0;

    // Pad model: buttons in serial slot order, 1 = pressed
    logic [15:0] pad_buttons = '0;
    logic [4:0]  pad_idx = '0;
    logic        pad_clk_q = 1'b1;

    // Reference state
    logic [7:0] model_rpt = '0;
    logic [7:0] model_prev = '0;
    int prev_t = -1;
    int rel_cyc = 0;
    bit after_reset = 1'b0;
    bit resync = 1'b0;

    snes_pad_reader #(
        .POLL_DIV  (POLL_DIV),
        .LATCH_CYC (LATCH_CYC),
        .HALF_CYC  (HALF_CYC),
        .NBITS     (NBITS)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .pad_data          (pad_data),
        .pad_latch         (pad_latch),
        .pad_clk           (pad_clk),
        .controller_report (controller_report),
        .report_valid      (report_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pad presents slot 0 while latched and advances one slot on each rising shift clock
    always @(posedge clk) begin
        pad_clk_q <= pad_clk;
        if (pad_latch === 1'b1) begin
            pad_idx <= '0;
        end else if (pad_clk === 1'b1 && pad_clk_q === 1'b0 && pad_idx < 5'd16) begin
            pad_idx <= pad_idx + 1'b1;
        end
    end

    assign pad_data = (pad_idx < 5'd16) ? ~pad_buttons[pad_idx[3:0]] : 1'b1;

    // Report layout: bit i of the report shows serial slot slot_of[i]
    function automatic logic [7:0] model_map(input logic [15:0] b);
        int slot_of [8] = '{0, 5, 6, 7, 3, 2, 8, 4};
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (slot_of[i] < NBITS) r[i] = b[slot_of[i]];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model_rpt  = '0;
        model_prev = '0;
    endtask

    task automatic run_poll(input int drop_at, input int reset_at);
        int t0, lat_hi, lows, low_len, bad_low, dcyc, guard;
        logic [7:0] mapped;
        guard = 0;
        while (pad_latch !== 1'b1 && guard < 450) begin
            @(negedge clk);
            guard++;
        end
        check("latch_rise", {31'd0, pad_latch}, 32'd1);
        if (pad_latch !== 1'b1) return;
        t0 = cyc;
        if (after_reset) check("latch_after_reset", t0 - rel_cyc, POLL_DIV);
        else if (resync) check("latch_phase", (t0 - prev_t) % POLL_DIV, 0);
        else if (prev_t >= 0) check("latch_period", t0 - prev_t, POLL_DIV);
        after_reset = 1'b0;
        resync = 1'b0;
        prev_t = t0;

        lat_hi = 0; lows = 0; low_len = 0; bad_low = 0; dcyc = -1;
        for (int i = 0; i < 2 * D_OFS; i++) begin
            if (i == drop_at) enable = 1'b0;
            if (i == reset_at) begin
                reset = 1'b1;
                #1;
                check("rst_latch", {31'd0, pad_latch}, 32'd0);
                check("rst_clk", {31'd0, pad_clk}, 32'd1);
                check("rst_report", {24'd0, controller_report}, 32'd0);
                check("rst_valid", {31'd0, report_valid}, 32'd0);
                model_reset();
                @(negedge clk);
                reset = 1'b0;
                rel_cyc = cyc;
                after_reset = 1'b1;
                $display("poll %0d: T=%0d reset at T+%0d", polls, t0, i);
                polls++;
                return;
            end
            if (report_valid === 1'b1) begin
                dcyc = i;
                break;
            end
            if (pad_latch === 1'b1) lat_hi++;
            if (pad_clk === 1'b0) low_len++;
            else if (low_len > 0) begin
                lows++;
                if (low_len != HALF_CYC) bad_low++;
                low_len = 0;
            end
            @(negedge clk);
        end

        mapped = model_map(pad_buttons);
`ifdef PAD_DEBOUNCE_EN
        if (mapped == model_prev) model_rpt = mapped;
        model_prev = mapped;
`else
        model_rpt = mapped;
`endif
        check("valid_at_D", dcyc, D_OFS);
        check("latch_width", lat_hi, LATCH_CYC);
        check("clk_pulses", lows, NBITS);
        check("clk_low_width", bad_low, 0);
        check("report", {24'd0, controller_report}, {24'd0, model_rpt});
        $display("poll %0d: T=%0d buttons=%04h report=%02h expected=%02h",
                 polls, t0, pad_buttons, controller_report, model_rpt);
        polls++;
        @(negedge clk);
        check("valid_width", {31'd0, report_valid}, 32'd0);
        check("report_hold", {24'd0, controller_report}, {24'd0, model_rpt});
    endtask

    initial begin
        int lat_seen, val_seen;
        logic [7:0] held;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_latch", {31'd0, pad_latch}, 32'd0);
        check("reset_clk", {31'd0, pad_clk}, 32'd1);
        check("reset_report", {24'd0, controller_report}, 32'd0);
        check("reset_valid", {31'd0, report_valid}, 32'd0);
        enable = 1'b1;
        reset = 1'b0;
        rel_cyc = cyc;
        after_reset = 1'b1;

        // Idle pad
        run_poll(-1, -1);

        // Start, then B+Right, each held for two polls
        pad_buttons = 16'h0008;
        run_poll(-1, -1);
        run_poll(-1, -1);
        pad_buttons = 16'h0081;
        run_poll(-1, -1);
        run_poll(-1, -1);

        // Random patterns, each held for two polls
        for (int n = 0; n < 4; n++) begin
            pad_buttons = 16'($urandom);
            run_poll(-1, -1);
            run_poll(-1, -1);
        end

        // Up for one poll only, then Up for two consecutive polls
        pad_buttons = 16'h0000;
        run_poll(-1, -1);
        pad_buttons = 16'h0010;
        run_poll(-1, -1);
        pad_buttons = 16'h0000;
        run_poll(-1, -1);
        pad_buttons = 16'h0010;
        run_poll(-1, -1);
        run_poll(-1, -1);

        // Enable dropped mid-poll: poll completes, then silence
        pad_buttons = 16'h0100;
        run_poll(50, -1);
        held = controller_report;
        lat_seen = 0;
        val_seen = 0;
        for (int i = 0; i < 2 * POLL_DIV + 50; i++) begin
            @(negedge clk);
            if (pad_latch === 1'b1) lat_seen++;
            if (report_valid === 1'b1) val_seen++;
        end
        check("disabled_no_latch", lat_seen, 0);
        check("disabled_no_valid", val_seen, 0);
        check("disabled_hold", {24'd0, controller_report}, {24'd0, held});

        // Re-enable; the latch stays on the free-running poll grid
        enable = 1'b1;
        resync = 1'b1;
        pad_buttons = 16'h0004;
        run_poll(-1, -1);

        // Reset at T+70, then a clean poll 200 cycles after release
        pad_buttons = 16'h0040;
        run_poll(-1, 70);
        run_poll(-1, -1);
        run_poll(-1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
